// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types: response codes, channel FSM encodings and small helpers.
package axi4lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Register index width; a single-register bank still carries a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte-lane merge of new write data into an existing register value.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4lite_slave_regs_if.sv
// AXI4-Lite bus bundle between master and register slave; wstrb exists only with AXI4LITE_WSTRB_EN.
interface axi4lite_slave_regs_if;
    import axi4lite_pkg::*;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
`ifdef AXI4LITE_WSTRB_EN
    logic [3:0]  wstrb;
`endif
    logic        wvalid;
    logic        wready;
    resp_t       bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    resp_t       rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata,
`ifdef AXI4LITE_WSTRB_EN
        output wstrb,
`endif
        output wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata,
`ifdef AXI4LITE_WSTRB_EN
        input  wstrb,
`endif
        input  wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4lite_addr_decode.sv
// Combinational byte-address to register-index decode with SLVERR/DECERR classification.
module axi4lite_addr_decode
    import axi4lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NREGS     = 8,
    localparam int unsigned IW       = idx_width(NREGS)
) (
    input  logic [31:0]   addr,
    output logic [IW-1:0] idx_c,
    output resp_t         resp_c
);

    logic [31:0] off;
    logic [29:0] word;

    // Negative offsets wrap to huge word numbers and so fall into DECERR.
    always_comb begin
        off   = addr - BASE_ADDR;
        word  = off[31:2];
        idx_c = word[IW-1:0];
        if (off[1:0] != 2'b00) begin
            resp_c = RESP_SLVERR;
        end else if ({2'b00, word} >= 32'(NREGS)) begin
            resp_c = RESP_DECERR;
        end else begin
            resp_c = RESP_OKAY;
        end
    end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave register bank with parallel register export and per-register write pulse.
// Define AXI4LITE_WSTRB_EN to enable byte strobes on the write channel.
module axi4lite_slave_regs
    import axi4lite_pkg::*;
#(
    parameter int unsigned NREGS     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   aclk,
    input  logic                   areset,
    axi4lite_slave_regs_if.slave   bus,
    output logic [NREGS*32-1:0]    reg_q,
    output logic [NREGS-1:0]       reg_wr
);

    localparam int unsigned IW = idx_width(NREGS);

    w_state_e    w_state_q, w_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    resp_t       bresp_q, bresp_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
`ifdef AXI4LITE_WSTRB_EN
    logic [3:0]  wstrb_q, wstrb_d;
    logic [3:0]  wstrb_c;
`endif

    r_state_e    r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    resp_t       rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0]      regs_q [NREGS];
    logic [31:0]      regs_d [NREGS];
    logic [NREGS-1:0] reg_wr_q, reg_wr_d;

    logic          aw_hs, w_hs, ar_hs;
    logic [31:0]   waddr_c, wdata_c, rd_word_c;
    logic [IW-1:0] widx, ridx;
    resp_t         wresp, rresp_c;

    assign aw_hs = bus.awvalid && awready_q;
    assign w_hs  = bus.wvalid  && wready_q;
    assign ar_hs = bus.arvalid && arready_q;

    // Commit uses whatever arrives this edge, otherwise the held copy.
    assign waddr_c = aw_hs ? bus.awaddr : awaddr_q;
    assign wdata_c = w_hs  ? bus.wdata  : wdata_q;
`ifdef AXI4LITE_WSTRB_EN
    assign wstrb_c = w_hs  ? bus.wstrb  : wstrb_q;
`endif

    axi4lite_addr_decode #(.BASE_ADDR(BASE_ADDR), .NREGS(NREGS)) u_aw_decode (
        .addr   (waddr_c),
        .idx_c  (widx),
        .resp_c (wresp)
    );

    axi4lite_addr_decode #(.BASE_ADDR(BASE_ADDR), .NREGS(NREGS)) u_ar_decode (
        .addr   (bus.araddr),
        .idx_c  (ridx),
        .resp_c (rresp_c)
    );

    always_comb begin
        rd_word_c = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (ridx == IW'(i)) rd_word_c = regs_q[i];
        end
    end

    // Write channel: independent AW/W capture, commit on completion, hold B until bready.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
`ifdef AXI4LITE_WSTRB_EN
        wstrb_d   = wstrb_q;
`endif
        regs_d    = regs_q;
        reg_wr_d  = '0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = bus.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = bus.wdata;
`ifdef AXI4LITE_WSTRB_EN
                    wstrb_d  = bus.wstrb;
`endif
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wresp;
                    if (wresp == RESP_OKAY) begin
                        for (int unsigned i = 0; i < NREGS; i++) begin
                            if (widx == IW'(i)) begin
`ifdef AXI4LITE_WSTRB_EN
                                regs_d[i] = apply_strb(regs_q[i], wdata_c, wstrb_c);
`else
                                regs_d[i] = wdata_c;
`endif
                                reg_wr_d[i] = 1'b1;
                            end
                        end
                    end
                end
                awready_d = (w_state_d == W_IDLE) && !aw_held_d;
                wready_d  = (w_state_d == W_IDLE) && !w_held_d;
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel: snapshot pre-write register value on AR acceptance, hold R until rready.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = rresp_c;
                    rdata_d   = (rresp_c == RESP_OKAY) ? rd_word_c : 32'h0;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    r_state_d = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
`ifdef AXI4LITE_WSTRB_EN
            wstrb_q   <= '0;
`endif
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            reg_wr_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
`ifdef AXI4LITE_WSTRB_EN
            wstrb_q   <= wstrb_d;
`endif
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            reg_wr_q  <= reg_wr_d;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
    assign reg_wr      = reg_wr_q;

    for (genvar g = 0; g < int'(NREGS); g++) begin : g_export
        assign reg_q[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed + randomized bench for axi4lite_slave_regs against an array-based register model.
`timescale 1ns/1ps
module tb_axi4lite_slave_regs;

    localparam int unsigned NREGS = 8;
    localparam logic [31:0] BASE  = 32'h4000_0100;

    logic aclk = 1'b0;
    logic areset;
    logic [NREGS*32-1:0] reg_q;
    logic [NREGS-1:0]    reg_wr;

    always #5 aclk = ~aclk;

    axi4lite_slave_regs_if bus();

    axi4lite_slave_regs #(.NREGS(NREGS), .BASE_ADDR(BASE)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus),
        .reg_q  (reg_q),
        .reg_wr (reg_wr)
    );

    logic [31:0] model [NREGS];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off % 4 != 0) return 2'b10;
        if (off / 4 >= NREGS) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int exp_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off / 4);
    endfunction

    function automatic logic [255:0] model_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
`ifdef AXI4LITE_WSTRB_EN
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
`else
        return (strb == 4'hF || strb != 4'hF) ? new_v : old_v;
`endif
    endfunction

    task automatic set_strb(input logic [3:0] strb);
`ifdef AXI4LITE_WSTRB_EN
        bus.wstrb = strb;
`else
        if (strb == 4'h0) bus.wdata = bus.wdata;
`endif
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
        @(negedge aclk);
        check("rst_awready", bus.awready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid",  bus.bvalid, 0);
        check("rst_bresp",   bus.bresp, 0);
        check("rst_rvalid",  bus.rvalid, 0);
        check("rst_rresp",   bus.rresp, 0);
        check("rst_rdata",   bus.rdata, 0);
        check("rst_reg_q",   reg_q, 0);
        check("rst_reg_wr",  reg_wr, 0);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_awready", bus.awready, 1);
        check("post_rst_wready",  bus.wready, 1);
        check("post_rst_arready", bus.arready, 1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_start, input int w_start, input int bdelay);
        int cyc = 0;
        bit aw_done = 0, w_done = 0;
        logic [1:0] er;
        logic [NREGS-1:0] exp_wr;
        er = exp_resp(addr);
        exp_wr = '0;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge aclk);
            check("pre_commit_bvalid", bus.bvalid, 0);
            if (w_done)  check("w_held_wready", bus.wready, 0);
            if (aw_done) check("aw_held_awready", bus.awready, 0);
            bus.awvalid = !aw_done && (cyc >= aw_start);
            bus.awaddr  = addr;
            bus.wvalid  = !w_done && (cyc >= w_start);
            bus.wdata   = data;
            set_strb(strb);
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready)   w_done = 1;
            cyc++;
        end
        check("write_handshake_done", aw_done && w_done, 1);
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0;
        if (er == 2'b00) begin
            model[exp_idx(addr)] = merge(model[exp_idx(addr)], data, strb);
            exp_wr[exp_idx(addr)] = 1'b1;
        end
        check("bvalid_rise", bus.bvalid, 1);
        check("bresp", bus.bresp, er);
        check("reg_wr_pulse", reg_wr, exp_wr);
        check("reg_q_after_write", reg_q, model_vec());
        for (int k = 0; k < bdelay; k++) begin
            @(negedge aclk);
            check("bvalid_hold", bus.bvalid, 1);
            check("bresp_hold", bus.bresp, er);
            check("awready_during_b", bus.awready, 0);
            check("reg_wr_one_cycle", reg_wr, 0);
        end
        bus.bready = 1;
        @(negedge aclk);
        bus.bready = 0;
        check("bvalid_drop", bus.bvalid, 0);
        check("awready_back", bus.awready, 1);
        check("reg_wr_idle", reg_wr, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdelay, output logic [31:0] got);
        int cyc = 0;
        logic [1:0] er;
        logic [31:0] ed;
        er = exp_resp(addr);
        @(negedge aclk);
        bus.arvalid = 1; bus.araddr = addr;
        while (!bus.arready && cyc < 20) begin
            @(negedge aclk);
            cyc++;
        end
        check("ar_accept", bus.arready, 1);
        ed = (er == 2'b00) ? model[exp_idx(addr)] : 32'h0;
        @(negedge aclk);
        bus.arvalid = 0;
        check("rvalid_rise", bus.rvalid, 1);
        check("rresp", bus.rresp, er);
        check("rdata", bus.rdata, ed);
        got = bus.rdata;
        for (int k = 0; k < rdelay; k++) begin
            @(negedge aclk);
            check("rvalid_hold", bus.rvalid, 1);
            check("rdata_hold", bus.rdata, ed);
            check("arready_during_r", bus.arready, 0);
        end
        bus.rready = 1;
        @(negedge aclk);
        bus.rready = 0;
        check("rvalid_drop", bus.rvalid, 0);
    endtask

    initial begin
        logic [31:0] got, old, addr, data;
        logic [3:0]  strb;
        areset = 1'b1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
        bus.awaddr = '0; bus.wdata = '0; bus.araddr = '0;
        set_strb(4'hF);
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        do_reset();

        // AW and W together, then read back
        axi_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(BASE + 32'h4, 0, got);
        check("deadbeef_readback", got, 32'hDEAD_BEEF);

        // W three cycles ahead of AW, and AW ahead of W
        axi_write(BASE + 32'h0, 32'h1234_5678, 4'hF, 3, 0, 0);
        axi_write(BASE + 32'h8, 32'h0BAD_F00D, 4'hF, 0, 2, 1);

        // DECERR, SLVERR and negative-offset DECERR
        axi_write(BASE + 32'h20, 32'hFFFF_0000, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h6, 32'hFFFF_0001, 4'hF, 1, 0, 0);
        axi_write(BASE - 32'h4, 32'hFFFF_0002, 4'hF, 0, 0, 0);
        axi_read(BASE + 32'h20, 0, got);
        axi_read(BASE + 32'h6, 1, got);

        // Long bready stall
        axi_write(BASE + 32'h1C, 32'hCAFE_0007, 4'hF, 0, 0, 5);

        // AR on the same edge as a write commit returns the old value
        @(negedge aclk);
        old = model[2];
        bus.awaddr = BASE + 32'h8; bus.wdata = 32'hAAAA_5555; set_strb(4'hF);
        bus.araddr = BASE + 32'h8;
        bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        check("coll_rvalid", bus.rvalid, 1);
        check("coll_rdata_old", bus.rdata, old);
        check("coll_bvalid", bus.bvalid, 1);
        model[2] = merge(model[2], 32'hAAAA_5555, 4'hF);
        check("coll_reg_q", reg_q, model_vec());
        bus.bready = 1; bus.rready = 1;
        @(negedge aclk);
        bus.bready = 0; bus.rready = 0;
        check("coll_bvalid_drop", bus.bvalid, 0);
        check("coll_rvalid_drop", bus.rvalid, 0);
        axi_read(BASE + 32'h8, 0, got);
        check("coll_new_value", got, 32'hAAAA_5555);

`ifdef AXI4LITE_WSTRB_EN
        axi_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0);
        axi_read(BASE + 32'hC, 0, got);
        check("wstrb_0101", got, 32'h00FF_00FF);
        axi_write(BASE + 32'hC, 32'h1111_1111, 4'b0000, 0, 0, 0);
        axi_read(BASE + 32'hC, 0, got);
        check("wstrb_none", got, 32'h00FF_00FF);
`endif

        // Randomized mix of reads and writes
        for (int n = 0; n < 60; n++) begin
            addr = BASE + 32'($urandom_range(0, 10)) * 4;
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) addr = BASE - 32'($urandom_range(1, 4)) * 4;
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3));
            else
                axi_read(addr, $urandom_range(0, 2), got);
        end

        // Reset while a response is pending aborts it and clears the bank
        @(negedge aclk);
        bus.awaddr = BASE + 32'h10; bus.wdata = 32'h5A5A_5A5A; set_strb(4'hF);
        bus.awvalid = 1; bus.wvalid = 1;
        @(negedge aclk);
        bus.awvalid = 0; bus.wvalid = 0;
        check("abort_bvalid_up", bus.bvalid, 1);
        do_reset();

        // A held AW is discarded by reset: a lone W afterwards must not commit
        @(negedge aclk);
        bus.awaddr = BASE + 32'h14; bus.awvalid = 1;
        @(negedge aclk);
        bus.awvalid = 0; areset = 1;
        @(negedge aclk);
        areset = 0;
        @(negedge aclk);
        bus.wdata = 32'h7777_7777; set_strb(4'hF); bus.wvalid = 1;
        @(negedge aclk);
        bus.wvalid = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            check("abort_no_commit_bvalid", bus.bvalid, 0);
            check("abort_no_commit_reg_wr", reg_wr, 0);
        end
        check("abort_reg_q", reg_q, model_vec());
        do_reset();
        axi_read(BASE + 32'h10, 0, got);
        check("abort_reg_cleared", got, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi4lite_slave_regs.md
# axi4lite_slave_regs

AXI4-Lite slave register bank that terminates the transactions issued by `axi4lite_master`. It holds NREGS 32-bit read/write registers, decodes word addresses relative to BASE_ADDR, and returns OKAY/SLVERR/DECERR responses. Register contents are exported in parallel to NoC-side logic, with a one-cycle write strobe per register.

## Interface
- NREGS, 8, number of 32-bit registers (1..256)
- BASE_ADDR, 32'h0000_0000, byte address of register 0; must be 4-byte aligned
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  synchronous, active-high reset
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes; present only with AXI4LITE_WSTRB_EN
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- reg_q  out  NREGS*32  register contents; register i is at [32*i+31:32*i]
- reg_wr  out  NREGS  one-cycle pulse on the register written

## Operation
- Decode: off = addr - BASE_ADDR (32-bit, wraps). off[1:0]!=0 -> SLVERR. off>>2 >= NREGS (including a negative offset wrapped to a large value) -> DECERR. Otherwise OKAY, index = off>>2.
- Write channel, states W_IDLE and W_RESP:
  - In W_IDLE, AW and W are captured independently, in any order or together. Each has its own held flag.
  - awready = !aw_held in W_IDLE. wready = !w_held in W_IDLE.
  - Commit happens on the edge where the second of AW/W is captured (or on the edge both are captured together). On OKAY the register is updated and reg_wr[index] pulses for the following cycle. On an error, nothing is written.
  - Then the channel moves to W_RESP: bvalid=1 with bresp, held stable until bready. On the bvalid&&bready edge, return to W_IDLE and clear both held flags.
- Read channel, states R_IDLE and R_DATA:
  - arready=1 only in R_IDLE. On AR acceptance, rdata and rresp are registered.
  - Error responses return rdata=0.
  - rvalid, rdata and rresp are held until rready, then the channel returns to R_IDLE.
- The read and write channels are fully independent. An AR accepted on the same edge as a write commit to the same register returns the pre-write value.
- Responses: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11. EXOKAY is never produced.

## Timing
- Reset values:
  - All registers 0; reg_q=0; reg_wr=0.
  - bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0.
  - awready=0 and arready=0 while areset=1.
  - Both FSMs in IDLE; held flags cleared.
- awready, wready and arready go to 1 in the first cycle after reset deasserts.
- Write latency: bvalid rises 1 cycle after the AW/W completion edge. Minimum throughput is one write per 2 cycles.
- Read latency: rvalid rises 1 cycle after the AR handshake. Minimum throughput is one read per 2 cycles.
- reg_q reflects a write 1 cycle after the commit edge, the same cycle as the reg_wr pulse and bvalid.
- Asserting areset mid-transaction aborts it. Outstanding valids drop the next cycle, and there is no partial write.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- AXI4LITE_WSTRB_EN defined:
  - The wstrb port exists.
  - Byte lane k is written only if wstrb[k]=1.
  - wstrb=0 gives an OKAY response with no data change, but reg_wr still pulses.
- AXI4LITE_WSTRB_EN undefined:
  - No wstrb port.
  - Every OKAY write replaces all 32 bits.

## Structure
- Shared package axi4lite_pkg holds:
  - response constants RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR
  - FSM state encodings
  - the 2-bit response type
- One sub-module, axi4lite_addr_decode:
  - parameters BASE_ADDR, NREGS
  - maps a 32-bit address to index and resp
  - instantiated twice: once for AW, once for AR

## Test plan
- Write 32'hDEAD_BEEF to BASE+0x4 with AW and W in the same cycle, then read BASE+0x4 -> bresp=00, reg_wr=8'b0000_0010 for 1 cycle, rdata=32'hDEAD_BEEF, rresp=00.
- Present W 3 cycles before AW (write 32'h1234_5678 to BASE+0x0) -> wready drops after the W capture, no commit until AW arrives, then bvalid=1 one cycle after the AW handshake.
- Write to BASE+0x20 with NREGS=8, then to BASE+0x6 -> bresp=11 then bresp=10. No reg_wr pulse and reg_q unchanged in both cases.
- Hold bready=0 for 5 cycles after a write -> bvalid and bresp stay stable, awready=0 throughout; a new write is accepted only after the bready handshake.
- Read BASE+0x8 on the same edge that a write of 32'hAAAA_5555 to BASE+0x8 commits -> rdata returns the old value; a subsequent read returns 32'hAAAA_5555.
- With AXI4LITE_WSTRB_EN: write 32'hFFFF_FFFF with wstrb=4'b0101 to a register holding 0 -> reg reads back 32'h00FF_00FF.
